// File: rtl/alu_seq_nbit.sv
// Sequential signed ALU: ADD/SUB complete in one step, MUL (shift-add) and
// DIV (restoring) iterate one bit per clock. Instructions enter through a
// valid/ready handshake and results leave through another. Only one
// operation is in flight at a time.
module alu_seq_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [2*WIDTH+1:0] i_instr,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  output logic [WIDTH-1:0]   o_y,
  output logic [WIDTH-1:0]   o_y1,
  output logic               o_c,
  output logic               o_o,
  output logic               o_z,
  output logic               o_dz,
  output logic               o_out_valid,
  input  logic               i_out_ready
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  localparam logic [WIDTH-1:0]   OneW  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] OneW2 = (2 * WIDTH)'(1);

  typedef enum logic [1:0] {StIdle, StExec, StFixup, StDone} state_e;

  state_e               r_state;
  logic [1:0]           r_op;
  logic                 r_sa;
  logic                 r_sb;
  logic [WIDTH-1:0]     r_opnd;   // |A| for MUL (multiplicand), |B| for DIV (divisor)
  // MUL: {partial product high, multiplier shifting out}
  // DIV: {partial remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_y;
  logic [WIDTH-1:0]     r_y1;
  logic                 r_c;
  logic                 r_o;
  logic                 r_z;
  logic                 r_dz;
  logic                 r_out_valid;

  // Instruction decode
  logic [1:0]         w_op;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_b_x;
  logic [WIDTH:0]     w_addsub;
  logic [WIDTH-1:0]   w_as_y;
  logic               w_as_o;

  assign w_op    = i_instr[2*WIDTH+1:2*WIDTH];
  assign w_a     = i_instr[2*WIDTH-1:WIDTH];
  assign w_b     = i_instr[WIDTH-1:0];
  // MIN maps onto 2^(WIDTH-1), which still fits as an unsigned magnitude
  assign w_a_mag = w_a[WIDTH-1] ? (~w_a + OneW) : w_a;
  assign w_b_mag = w_b[WIDTH-1] ? (~w_b + OneW) : w_b;

  // SUB is A + ~B + 1 so the carry out is the no-borrow flag
  assign w_b_x    = (w_op == OpSub) ? ~w_b : w_b;
  assign w_addsub = {1'b0, w_a} + {1'b0, w_b_x} + {{WIDTH{1'b0}}, (w_op == OpSub)};
  assign w_as_y   = w_addsub[WIDTH-1:0];
  assign w_as_o   = (w_a[WIDTH-1] == w_b_x[WIDTH-1]) && (w_as_y[WIDTH-1] != w_a[WIDTH-1]);

  // One shift-add multiply step
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring divide step; remainder stays below the divisor so the
  // shifted value is below 2^WIDTH and the difference sign bit is exact
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_next  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIXUP
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_mul_o;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div_o;

  assign w_neg   = r_sa ^ r_sb;
  assign w_prod  = w_neg ? (~r_acc + OneW2) : r_acc;
  assign w_mul_o = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
  assign w_quo   = w_neg ? (~r_acc[WIDTH-1:0] + OneW) : r_acc[WIDTH-1:0];
  assign w_rem   = r_sa ? (~r_acc[2*WIDTH-1:WIDTH] + OneW) : r_acc[2*WIDTH-1:WIDTH];
  // A positive quotient with its top bit set can only be MIN/-1
  assign w_div_o = !w_neg && r_acc[WIDTH-1];

  assign o_in_ready  = (r_state == StIdle) && !i_rst;
  assign o_y         = r_y;
  assign o_y1        = r_y1;
  assign o_c         = r_c;
  assign o_o         = r_o;
  assign o_z         = r_z;
  assign o_dz        = r_dz;
  assign o_out_valid = r_out_valid;

  // Control FSM, iteration datapath and registered results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_op        <= OpAdd;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_y         <= '0;
      r_y1        <= '0;
      r_c         <= 1'b0;
      r_o         <= 1'b0;
      r_z         <= 1'b0;
      r_dz        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_op  <= w_op;
            r_sa  <= w_a[WIDTH-1];
            r_sb  <= w_b[WIDTH-1];
            r_cnt <= CW'(WIDTH - 1);
            unique case (w_op)
              OpAdd, OpSub: begin
                r_y     <= w_as_y;
                r_y1    <= {WIDTH{w_as_y[WIDTH-1]}};
                r_c     <= w_addsub[WIDTH];
                r_o     <= w_as_o;
                r_z     <= (w_as_y == '0);
                r_dz    <= 1'b0;
                r_state <= StDone;
              end
              OpMul: begin
                r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                r_opnd  <= w_a_mag;
                r_state <= StExec;
              end
              OpDiv: begin
                if (w_b == '0) begin
                  r_y     <= '1;
                  r_y1    <= w_a;
                  r_c     <= 1'b0;
                  r_o     <= 1'b0;
                  r_z     <= 1'b0;
                  r_dz    <= 1'b1;
                  r_state <= StDone;
                end else begin
                  r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                  r_opnd  <= w_b_mag;
                  r_state <= StExec;
                end
              end
              default: r_state <= StIdle;
            endcase
          end
        end
        StExec: begin
          r_acc <= (r_op == OpMul) ? w_mul_next : w_div_next;
          if (r_cnt == '0) begin
            r_state <= StFixup;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        StFixup: begin
          r_c  <= 1'b0;
          r_dz <= 1'b0;
          if (r_op == OpMul) begin
            r_y  <= w_prod[WIDTH-1:0];
            r_y1 <= w_prod[2*WIDTH-1:WIDTH];
            r_o  <= w_mul_o;
            r_z  <= (w_prod[WIDTH-1:0] == '0);
          end else begin
            r_y  <= w_quo;
            r_y1 <= w_rem;
            r_o  <= w_div_o;
            r_z  <= (w_quo == '0);
          end
          r_state <= StDone;
        end
        StDone: begin
          // Results are already stable here; valid rises one cycle later
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed bench for alu_seq_nbit at WIDTH=8.
module tb_alu_seq_nbit;

  localparam int unsigned W = 8;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  logic           clk;
  logic           rst;
  logic [2*W+1:0] instr;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   y;
  logic [W-1:0]   y1;
  logic           c;
  logic           o;
  logic           z;
  logic           dz;
  logic           out_valid;
  logic           out_ready;

  int n_vec;
  int n_fail;

  alu_seq_nbit #(.WIDTH(W)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_instr     (instr),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_y         (y),
    .o_y1        (y1),
    .o_c         (c),
    .o_o         (o),
    .o_z         (z),
    .o_dz        (dz),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid after the accept edge; returns edges counted (40 on timeout)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat, input logic [7:0] ey,
                       input logic [7:0] ey1, input logic [3:0] eflags);
    int lat;
    instr    = {op, a, b};
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = '1;
    wait_valid(lat);
    chk({tag, ".latency"}, 16'(lat), 16'(exp_lat));
    chk({tag, ".y1y"}, {y1, y}, {ey1, ey});
    chk({tag, ".c_o_z_dz"}, 16'({c, o, z, dz}), 16'(eflags));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".handoff"}, 16'({out_valid, in_ready}), 16'b01);
  endtask

  initial begin
    int lat;
    logic seen;
    n_vec     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    instr     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", {y1, y}, 16'h0000);
    chk("reset.flags_valid_ready", 16'({c, o, z, dz, out_valid, in_ready}), 16'h0000);
    rst = 1'b0;
    #1;
    chk("reset.in_ready_after", 16'(in_ready), 16'd1);

    // Flags packed as {C, O, Z, DZ}
    do_op("add_6_4",      OpAdd, 8'h06, 8'h04, 1,  8'h0A, 8'h00, 4'b0000);
    do_op("sub_6_4",      OpSub, 8'h06, 8'h04, 1,  8'h02, 8'h00, 4'b1000);
    do_op("add_m128_m16", OpAdd, 8'h80, 8'hF0, 1,  8'h70, 8'h00, 4'b1100);
    do_op("add_127_125",  OpAdd, 8'h7F, 8'h7D, 1,  8'hFC, 8'hFF, 4'b0100);
    do_op("sub_5_5",      OpSub, 8'h05, 8'h05, 1,  8'h00, 8'h00, 4'b1010);
    do_op("sub_0_1",      OpSub, 8'h00, 8'h01, 1,  8'hFF, 8'hFF, 4'b0000);
    do_op("mul_m6_4",     OpMul, 8'hFA, 8'h04, 10, 8'hE8, 8'hFF, 4'b0000);
    do_op("mul_127_127",  OpMul, 8'h7F, 8'h7F, 10, 8'h01, 8'h3F, 4'b0100);
    do_op("mul_0_m5",     OpMul, 8'h00, 8'hFB, 10, 8'h00, 8'h00, 4'b0010);
    do_op("mul_m128_m128",OpMul, 8'h80, 8'h80, 10, 8'h00, 8'h40, 4'b0110);
    do_op("div_m7_2",     OpDiv, 8'hF9, 8'h02, 10, 8'hFD, 8'hFF, 4'b0000);
    do_op("div_7_m2",     OpDiv, 8'h07, 8'hFE, 10, 8'hFD, 8'h01, 4'b0000);
    do_op("div_3_5",      OpDiv, 8'h03, 8'h05, 10, 8'h00, 8'h03, 4'b0010);
    do_op("div_5_0",      OpDiv, 8'h05, 8'h00, 1,  8'hFF, 8'h05, 4'b0001);
    do_op("div_m128_m1",  OpDiv, 8'h80, 8'hFF, 10, 8'h80, 8'h00, 4'b0100);

    // Backpressure: MUL 3*5 held in DONE while a competing ADD is offered
    instr    = {OpMul, 8'h03, 8'h05};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp.latency", 16'(lat), 16'd10);
    instr    = {OpAdd, 8'h01, 8'h01};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.hold_y1y", {y1, y}, 16'h000F);
      chk("bp.hold_valid_ready", 16'({out_valid, in_ready}), 16'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp.release", 16'({out_valid, in_ready}), 16'b01);
    do_op("bp.next_add_2_3", OpAdd, 8'h02, 8'h03, 1, 8'h05, 8'h00, 4'b0000);

    // Reset during the third EXEC cycle of a MUL
    instr    = {OpMul, 8'hFA, 8'h04};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid.y1y", {y1, y}, 16'h0000);
    chk("rst_mid.flags_valid_ready", 16'({c, o, z, dz, out_valid, in_ready}), 16'h0000);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("rst_mid.no_result", 16'(seen), 16'd0);
    do_op("rst_mid.add_1_1", OpAdd, 8'h01, 8'h01, 1, 8'h02, 8'h00, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
